// File: rtl/sort_pkg.sv
// Shared definitions for the sort loader: operand geometry and loader state encoding.
package sort_pkg;
  localparam int OP_W  = 4;
  localparam int OP_N  = 4;
  localparam int IDX_W = $clog2(OP_N);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FULL = 2'd1,
    GO   = 2'd2
  } loader_state_t;
endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, optional debounce, rising-edge press pulse.
// Debounce is built only when SORT_LOADER_DEBOUNCE_EN is defined.
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  logic [1:0] sync;
  logic [1:0] vld;
  logic       armed;
  logic       level;
  logic       prev;

  // DB_CYCLES below 2 is not a supported configuration.
  if (DB_CYCLES < 2) begin : g_db_cycles_too_small
  end

`ifdef SORT_LOADER_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);
  logic [CW-1:0] cnt;
  logic          db_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      db_level <= 1'b0;
    end else if (!vld[1] || (sync[1] == db_level)) begin
      cnt <= '0;
    end else if (cnt == CW'(DB_CYCLES - 1)) begin
      db_level <= sync[1];
      cnt      <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = db_level;
`else
  assign level = sync[1];
`endif

  // vld marks when sync[1] holds a real btn sample rather than reset zeros; a press
  // is only honoured after a genuine low, so a button held through reset is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      vld   <= '0;
      armed <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      vld  <= {vld[0], 1'b1};
      prev <= level;
      if (vld[1] && !sync[1]) armed <= 1'b1;
    end
  end

  assign press = armed & level & ~prev;
endmodule

// File: rtl/sort_loader.sv
// Operand loader for the sorter: one button press per operand, a final press launches the sort.
// Optional button debounce is enabled with SORT_LOADER_DEBOUNCE_EN.
module sort_loader
  import sort_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] sw,
  input  logic            btn,
  output logic [OP_W-1:0] x0,
  output logic [OP_W-1:0] x1,
  output logic [OP_W-1:0] x2,
  output logic [OP_W-1:0] x3,
  output logic [1:0]      idx,
  output logic            full,
  output logic            start,
  output logic [1:0]      dbg_state
);
  logic            press;
  loader_state_t   state, state_nxt;
  logic            wr_en;
  logic [OP_W-1:0] x_q [OP_N];

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .press (press)
  );

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    case (state)
      LOAD: begin
        if (press) begin
          wr_en = 1'b1;
          if (idx == IDX_W'(OP_N - 1)) state_nxt = FULL;
        end
      end
      FULL:    if (press) state_nxt = GO;
      GO:      state_nxt = LOAD;  // a press landing here is dropped
      default: state_nxt = LOAD;
    endcase
  end

  // full/start are registered from the next state so they align with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      idx   <= '0;
      full  <= 1'b0;
      start <= 1'b0;
      for (int i = 0; i < OP_N; i++) x_q[i] <= '0;
    end else begin
      state <= state_nxt;
      full  <= (state_nxt == FULL);
      start <= (state_nxt == GO);
      if (wr_en) begin
        x_q[idx] <= sw;
        idx      <= idx + 1'b1;
      end
    end
  end

  assign x0        = x_q[0];
  assign x1        = x_q[1];
  assign x2        = x_q[2];
  assign x3        = x_q[3];
  assign dbg_state = state;
endmodule

// File: tb/tb_sort_loader.sv
// Directed bench for sort_loader: load, launch, hold, reset abort and sw sampling scenarios.
module tb_sort_loader;
  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [3:0] sw;
  logic [3:0] x0, x1, x2, x3;
  logic [1:0] idx;
  logic       full;
  logic       start;
  logic [1:0] dbg_state;

`ifdef SORT_LOADER_DEBOUNCE_EN
  localparam int LAT  = 19;
  localparam int HOLD = 40;
  localparam int IDLE = 40;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 8;
  localparam int IDLE = 8;
`endif
  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_FULL = 2'd1;
  localparam logic [1:0] S_GO   = 2'd2;

  int n_checks = 0;
  int n_fail   = 0;

  sort_loader #(.DB_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn       (btn),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .idx       (idx),
    .full      (full),
    .start     (start),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    btn = 1'b0;
    sw  = 4'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (IDLE) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] v);
    @(negedge clk);
    sw  = v;
    btn = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn = 1'b0;
    repeat (IDLE) @(negedge clk);
  endtask

  // sw changes every cycle: value set at negedge k is 4'(k*5+base).
  task automatic toggle_press(input int base);
    @(negedge clk);
    for (int k = 0; k < HOLD; k++) begin
      if (k == 0) btn = 1'b1;
      sw = 4'(k * 5 + base);
      @(negedge clk);
    end
    btn = 1'b0;
    for (int k = 0; k < IDLE; k++) begin
      sw = 4'(k * 3 + base + 1);
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({x0, x1, x2, x3} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_x: got %h expected 0000", {x0, x1, x2, x3});
    end
    n_checks++;
    if (idx !== 2'd0 || full !== 1'b0 || start !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got idx=%0d full=%b start=%b expected 0 0 0", idx, full, start);
    end
    n_checks++;
    if (dbg_state !== S_LOAD) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_LOAD);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    sw  = 4'd3;
    btn = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    n_checks++;
    if (idx !== 2'd0) begin
      n_fail++; $display("FAIL write_early: got idx=%0d expected 0", idx);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (idx !== 2'd1 || x0 !== 4'd3) begin
      n_fail++; $display("FAIL write_edge: got idx=%0d x0=%0d expected 1 3", idx, x0);
    end
    repeat (HOLD) @(negedge clk);
    btn = 1'b0;
    repeat (IDLE) @(negedge clk);
    press(4'd9);
    press(4'd1);
    n_checks++;
    if (full !== 1'b0) begin
      n_fail++; $display("FAIL full_early: got %b expected 0", full);
    end
    press(4'd7);
    n_checks++;
    if ({x0, x1, x2, x3} !== 16'h3917) begin
      n_fail++; $display("FAIL load_x: got %h expected 3917", {x0, x1, x2, x3});
    end
    n_checks++;
    if (idx !== 2'd0 || full !== 1'b1 || start !== 1'b0 || dbg_state !== S_FULL) begin
      n_fail++; $display("FAIL load_full: got idx=%0d full=%b start=%b st=%0d expected 0 1 0 %0d",
                         idx, full, start, dbg_state, S_FULL);
    end
  endtask

  task automatic test_launch();
    int start_cnt = 0;
    int start_at  = -1;
    @(negedge clk);
    sw  = 4'hF;
    btn = 1'b1;
    for (int i = 0; i < HOLD + IDLE; i++) begin
      @(posedge clk);
      #1;
      if (i == HOLD) btn = 1'b0;
      if (start === 1'b1) begin
        start_cnt++;
        if (start_at < 0) start_at = i;
        n_checks++;
        if (full !== 1'b0 || dbg_state !== S_GO) begin
          n_fail++; $display("FAIL go_state: got full=%b st=%0d expected 0 %0d", full, dbg_state, S_GO);
        end
      end
    end
    n_checks++;
    if (start_cnt !== 1) begin
      n_fail++; $display("FAIL start_width: got %0d cycles expected 1", start_cnt);
    end
    n_checks++;
    if (start_at !== LAT - 1) begin
      n_fail++; $display("FAIL start_time: got edge %0d expected %0d", start_at, LAT - 1);
    end
    n_checks++;
    if ({x0, x1, x2, x3} !== 16'h3917 || idx !== 2'd0) begin
      n_fail++; $display("FAIL launch_hold: got x=%h idx=%0d expected 3917 0", {x0, x1, x2, x3}, idx);
    end
    n_checks++;
    if (full !== 1'b0 || dbg_state !== S_LOAD) begin
      n_fail++; $display("FAIL launch_return: got full=%b st=%0d expected 0 %0d", full, dbg_state, S_LOAD);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    sw  = 4'd5;
    btn = 1'b1;
    repeat (50) @(negedge clk);
    btn = 1'b0;
    repeat (IDLE) @(negedge clk);
    n_checks++;
    if ({x0, x1, x2, x3} !== 16'h5917 || idx !== 2'd1) begin
      n_fail++; $display("FAIL hold_single: got x=%h idx=%0d expected 5917 1", {x0, x1, x2, x3}, idx);
    end
  endtask

  task automatic test_sw_toggle();
    logic [3:0] exp1, exp2;
    exp1 = 4'((LAT - 1) * 5 + 2);
    exp2 = 4'((LAT - 1) * 5 + 7);
    toggle_press(2);
    toggle_press(7);
    n_checks++;
    if (x1 !== exp1 || x2 !== exp2) begin
      n_fail++; $display("FAIL sw_sample: got x1=%h x2=%h expected %h %h", x1, x2, exp1, exp2);
    end
    n_checks++;
    if (x0 !== 4'd5 || x3 !== 4'd7 || idx !== 2'd3) begin
      n_fail++; $display("FAIL sw_others: got x0=%h x3=%h idx=%0d expected 5 7 3", x0, x3, idx);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    press(4'd3);
    press(4'd9);
    n_checks++;
    if (idx !== 2'd2) begin
      n_fail++; $display("FAIL mid_pre: got idx=%0d expected 2", idx);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({x0, x1, x2, x3} !== 16'h0000 || idx !== 2'd0 || full !== 1'b0 ||
        start !== 1'b0 || dbg_state !== S_LOAD) begin
      n_fail++; $display("FAIL async_reset: got x=%h idx=%0d full=%b start=%b st=%0d expected all 0",
                         {x0, x1, x2, x3}, idx, full, start, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (IDLE) @(negedge clk);
    press(4'd8);
    n_checks++;
    if (x0 !== 4'd8 || x1 !== 4'd0 || idx !== 2'd1) begin
      n_fail++; $display("FAIL after_reset: got x0=%h x1=%h idx=%0d expected 8 0 1", x0, x1, idx);
    end
  endtask

  task automatic test_btn_through_reset();
    @(negedge clk);
    sw  = 4'd11;
    btn = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30 + HOLD) @(negedge clk);
    n_checks++;
    if (idx !== 2'd0 || x0 !== 4'd0) begin
      n_fail++; $display("FAIL held_reset: got idx=%0d x0=%h expected 0 0", idx, x0);
    end
    btn = 1'b0;
    repeat (IDLE) @(negedge clk);
    press(4'd6);
    n_checks++;
    if (x0 !== 4'd6 || idx !== 2'd1) begin
      n_fail++; $display("FAIL held_repress: got x0=%h idx=%0d expected 6 1", x0, idx);
    end
  endtask

`ifdef SORT_LOADER_DEBOUNCE_EN
  task automatic test_debounce();
    int hit = -1;
    apply_reset();
    @(negedge clk);
    sw  = 4'hD;
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (IDLE) @(negedge clk);
    n_checks++;
    if (idx !== 2'd0 || x0 !== 4'd0) begin
      n_fail++; $display("FAIL glitch: got idx=%0d x0=%h expected 0 0", idx, x0);
    end
    @(negedge clk);
    btn = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (idx == 2'd1 && hit < 0) hit = e;
    end
    btn = 1'b0;
    repeat (IDLE) @(negedge clk);
    n_checks++;
    if (hit !== 19 || x0 !== 4'hD || idx !== 2'd1) begin
      n_fail++; $display("FAIL debounce_press: got edge=%0d x0=%h idx=%0d expected 19 d 1", hit, x0, idx);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    sw  = 4'h0;
    test_reset();
    test_load();
    test_launch();
    test_hold();
    test_sw_toggle();
    test_reset_mid();
    test_btn_through_reset();
`ifdef SORT_LOADER_DEBOUNCE_EN
    test_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
